// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm controller
//
// Purpose : state encoding, mode codes, time-field limits and widths used by
//           alarm_controller and wrap_inc.
// Ports   : none (package).
package alarm_pkg;

  localparam int TW      = 6;   // width of an hour or minute field
  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;

  typedef enum logic [2:0] {
    ST_NORMAL    = 3'd0,
    ST_SET_TIME  = 3'd1,
    ST_SET_ALARM = 3'd2,
    ST_RINGING   = 3'd3,
    ST_SNOOZE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_NORMAL    = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;
  localparam logic [1:0] MODE_ALERT     = 2'd3;

  // Both alert states share one externally visible mode code.
  function automatic logic [1:0] mode_of(input state_t s);
    logic [1:0] m;
    m = MODE_NORMAL;
    case (s)
      ST_SET_TIME:  m = MODE_SET_TIME;
      ST_SET_ALARM: m = MODE_SET_ALARM;
      ST_RINGING:   m = MODE_ALERT;
      ST_SNOOZE:    m = MODE_ALERT;
      default:      m = MODE_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wrap_inc.sv
// rtl/wrap_inc.sv - time-field increment that wraps to zero past a maximum
//
// Purpose : combinational +1 on a TW-bit field; MAX (and anything above it)
//           rolls over to 0.
// Ports   : i_val  in  TW  current field value
//           o_val  out TW  incremented / wrapped value
module wrap_inc
  import alarm_pkg::*;
#(
  parameter int MAX = MIN_MAX
) (
  input  logic [TW-1:0] i_val,
  output logic [TW-1:0] o_val
);

  localparam logic [TW-1:0] L_MAX = TW'(MAX);

  // Out-of-range inputs also roll to 0 so a bad value can never get stuck.
  assign o_val = (i_val >= L_MAX) ? '0 : i_val + 1'b1;

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm clock control FSM: time set, alarm set, ring and snooze
//
// Purpose : user-interface controller for a clock. Edits a staged copy of the
//           current time and loads it back with a one-cycle strobe, edits the
//           stored alarm time, and rings / snoozes when the time reaches the
//           alarm. All outputs are registered.
// Ports   : clk                         in   single clock, rising edge
//           reset                       in   synchronous, active-low
//           one_minute                  in   1-cycle minute tick
//           cur_hr, cur_min             in   current time (binary)
//           btn_time, btn_alarm, btn_hr,
//           btn_min, btn_snooze         in   1-cycle button pulses
//           alarm_on                    in   arm switch (level)
//           new_time                    out  1-cycle load strobe
//           new_time_hr, new_time_min   out  load value
//           alarm_hr, alarm_min         out  stored alarm time
//           show_alarm                  out  display shows alarm time
//           buzz                        out  sounder drive
//           mode                        out  0 normal, 1 set time, 2 set alarm, 3 alert
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 60
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          one_minute,
  input  logic [TW-1:0] cur_hr,
  input  logic [TW-1:0] cur_min,
  input  logic          btn_time,
  input  logic          btn_alarm,
  input  logic          btn_hr,
  input  logic          btn_min,
  input  logic          btn_snooze,
  input  logic          alarm_on,
  output logic          new_time,
  output logic [TW-1:0] new_time_hr,
  output logic [TW-1:0] new_time_min,
  output logic [TW-1:0] alarm_hr,
  output logic [TW-1:0] alarm_min,
  output logic          show_alarm,
  output logic          buzz,
  output logic [1:0]    mode
);

  localparam int RCW = (RING_MIN   < 1) ? 1 : $clog2(RING_MIN + 1);
  localparam int SCW = (SNOOZE_MIN < 1) ? 1 : $clog2(SNOOZE_MIN + 1);

  localparam logic [RCW-1:0] L_RING_MIN   = RCW'(RING_MIN);
  localparam logic [SCW-1:0] L_SNOOZE_MIN = SCW'(SNOOZE_MIN);

  state_t          r_state, w_nxt_state;
  logic [TW-1:0]   r_stg_hr, r_stg_min, w_nxt_stg_hr, w_nxt_stg_min;
  logic [TW-1:0]   w_nxt_alarm_hr, w_nxt_alarm_min;
  logic [TW-1:0]   w_nxt_nt_hr, w_nxt_nt_min;
  logic            w_nxt_new_time;
  logic [RCW-1:0]  r_ring_cnt, w_nxt_ring_cnt, w_ring_inc;
  logic [SCW-1:0]  r_snz_cnt, w_nxt_snz_cnt;
  logic            r_match_q, w_match;

  logic [TW-1:0]   w_stg_hr_inc, w_stg_min_inc, w_alarm_hr_inc, w_alarm_min_inc;

  wrap_inc #(.MAX(HR_MAX))  u_inc_stg_hr    (.i_val(r_stg_hr),  .o_val(w_stg_hr_inc));
  wrap_inc #(.MAX(MIN_MAX)) u_inc_stg_min   (.i_val(r_stg_min), .o_val(w_stg_min_inc));
  wrap_inc #(.MAX(HR_MAX))  u_inc_alarm_hr  (.i_val(alarm_hr),  .o_val(w_alarm_hr_inc));
  wrap_inc #(.MAX(MIN_MAX)) u_inc_alarm_min (.i_val(alarm_min), .o_val(w_alarm_min_inc));

  assign w_match    = (cur_hr == alarm_hr) && (cur_min == alarm_min);
  assign w_ring_inc = r_ring_cnt + 1'b1;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_stg_hr    = r_stg_hr;
    w_nxt_stg_min   = r_stg_min;
    w_nxt_alarm_hr  = alarm_hr;
    w_nxt_alarm_min = alarm_min;
    w_nxt_nt_hr     = new_time_hr;
    w_nxt_nt_min    = new_time_min;
    w_nxt_new_time  = 1'b0;
    w_nxt_ring_cnt  = r_ring_cnt;
    w_nxt_snz_cnt   = r_snz_cnt;

    case (r_state)
      ST_NORMAL: begin
        if (btn_time) begin
          w_nxt_state   = ST_SET_TIME;
          w_nxt_stg_hr  = cur_hr;
          w_nxt_stg_min = cur_min;
        end else if (btn_alarm) begin
          w_nxt_state = ST_SET_ALARM;
        end else if (w_match && !r_match_q && alarm_on) begin
          // Rising edge of match only, so a match that is still true on
          // return to NORMAL cannot restart the alarm.
          w_nxt_state    = ST_RINGING;
          w_nxt_ring_cnt = '0;
        end
      end

      ST_SET_TIME: begin
        if (btn_hr)  w_nxt_stg_hr  = w_stg_hr_inc;
        if (btn_min) w_nxt_stg_min = w_stg_min_inc;
        if (btn_time) begin
          // Commit includes an increment pressed on the same edge.
          w_nxt_state    = ST_NORMAL;
          w_nxt_new_time = 1'b1;
          w_nxt_nt_hr    = w_nxt_stg_hr;
          w_nxt_nt_min   = w_nxt_stg_min;
        end else if (btn_alarm) begin
          w_nxt_state = ST_NORMAL;
        end
      end

      ST_SET_ALARM: begin
        if (btn_hr)    w_nxt_alarm_hr  = w_alarm_hr_inc;
        if (btn_min)   w_nxt_alarm_min = w_alarm_min_inc;
        if (btn_alarm) w_nxt_state     = ST_NORMAL;
      end

      ST_RINGING: begin
        if (!alarm_on) begin
          w_nxt_state = ST_NORMAL;
        end else if (btn_snooze) begin
          w_nxt_state   = ST_SNOOZE;
          w_nxt_snz_cnt = L_SNOOZE_MIN;
        end else if (one_minute) begin
          w_nxt_ring_cnt = w_ring_inc;
          if (w_ring_inc >= L_RING_MIN) w_nxt_state = ST_NORMAL;
        end
      end

      ST_SNOOZE: begin
        if (!alarm_on) begin
          w_nxt_state = ST_NORMAL;
        end else if (one_minute) begin
          // <=1 also covers a zero-length snooze without underflow.
          if (r_snz_cnt <= 1) begin
            w_nxt_snz_cnt  = '0;
            w_nxt_state    = ST_RINGING;
            w_nxt_ring_cnt = '0;
          end else begin
            w_nxt_snz_cnt = r_snz_cnt - 1'b1;
          end
        end
      end

      default: w_nxt_state = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_NORMAL;
      r_stg_hr     <= '0;
      r_stg_min    <= '0;
      alarm_hr     <= '0;
      alarm_min    <= '0;
      new_time     <= 1'b0;
      new_time_hr  <= '0;
      new_time_min <= '0;
      r_ring_cnt   <= '0;
      r_snz_cnt    <= '0;
      r_match_q    <= 1'b1;  // blocks a trigger on the first cycle out of reset
      show_alarm   <= 1'b0;
      buzz         <= 1'b0;
      mode         <= MODE_NORMAL;
    end else begin
      r_state      <= w_nxt_state;
      r_stg_hr     <= w_nxt_stg_hr;
      r_stg_min    <= w_nxt_stg_min;
      alarm_hr     <= w_nxt_alarm_hr;
      alarm_min    <= w_nxt_alarm_min;
      new_time     <= w_nxt_new_time;
      new_time_hr  <= w_nxt_nt_hr;
      new_time_min <= w_nxt_nt_min;
      r_ring_cnt   <= w_nxt_ring_cnt;
      r_snz_cnt    <= w_nxt_snz_cnt;
      r_match_q    <= w_match;
      show_alarm   <= (w_nxt_state == ST_SET_ALARM);
      buzz         <= (w_nxt_state == ST_RINGING);
      mode         <= mode_of(w_nxt_state);
    end
  end

endmodule
